cla_seq_adder: RTL
==================

# cla_seq_adder

Nibble-serial multi-word adder/subtractor controller that time-shares one `cla_4bit` instance across `NIBBLES` passes to produce a `4*NIBBLES`-bit result. It latches operands on a start pulse and steps one nibble per clock, least-significant first, through the CLA. Between passes it holds the carry in a register. It reports completion with a one-cycle `done` pulse. It sits between a requesting datapath/ALU sequencer and the shared 4-bit CLA, trading latency for area.

## Interface
- `NIBBLES`, default 4: number of 4-bit passes; operand width W = 4*NIBBLES; legal range 2..16.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `sub` in 1: 0 = add (A + B + cin); 1 = subtract (A - B, computed as A + ~B + 1; `cin` ignored). Latched with `start`.
- `cin` in 1: carry-in for add; latched with `start`.
- `op_a` in W: operand A; latched with `start`.
- `op_b` in W: operand B; latched with `start`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `result`/`cout`/`overflow` valid.
- `result` out W: sum/difference; registered.
- `cout` out 1: final carry out of the MSB nibble. For subtract, 1 = no borrow.
- `overflow` out 1: two's-complement signed overflow, computed as (carry into bit W-1) XOR `cout`.

## Operation
- FSM states:
  - **IDLE → RUN** on `start`=1:
    - latch `op_a`; latch `op_b`, inverted if `sub`;
    - carry register ← (`sub` ? 1 : `cin`);
    - nibble index ← 0; `busy` ← 1.
  - **RUN**, each cycle:
    - CLA a = A[idx], b = B'[idx], cin = carry register;
    - `result` nibble idx ← CLA `sum`; carry register ← CLA `cout`; idx ← idx+1.
  - **RUN → DONE** on the cycle that processes idx = NIBBLES-1:
    - `cout` ← final carry; `overflow` ← final carry XOR carry into bit W-1.
    - The carry into bit W-1 is A[W-1] ^ B'[W-1] ^ sum bit 3 of the last pass.
  - **DONE**: `done`=1, `busy`=0 for exactly one cycle, then → IDLE unconditionally.
- `start` is ignored in RUN and DONE; there is no queuing. `start` high during the DONE cycle is not accepted. `start` high in the following IDLE cycle is accepted.
- The index counter is ceil(log2(NIBBLES)) bits wide and does not wrap mid-operation; it is reset to 0 on every accepted start.
- Nibbles of `result` not yet written in the current operation hold stale values. Consumers must read `result` only on or after `done`.
- `result`, `cout` and `overflow` hold their values after DONE until the next operation writes them.

## Timing
- Reset values: state IDLE; `busy`, `done`, `cout`, `overflow` = 0; `result` = 0; carry register and index = 0.
- `start` sampled at edge T0 → `busy` high from T0 to T(NIBBLES).
- Nibble k is registered at edge T(k+1).
- `done` is high from T(NIBBLES+1) to T(NIBBLES+2). `busy` and `done` are never high together.
- Latency from start edge to done asserted: NIBBLES+1 edges. Minimum start-to-start spacing: NIBBLES+2 cycles.
- `rst` mid-operation, at any edge: immediate return to IDLE with all reset values. The aborted operation produces no `done`.
- `rst` and `start` high at the same edge: `rst` wins; the start is dropped.
- The combinational path is one 4-bit CLA plus the operand nibble mux per cycle. No combinational path from `start` to any output.

## Test plan
All scenarios use NIBBLES=4.
1. **Basic add:** `op_a`=16'h1234, `op_b`=16'h4321, `cin`=0, `sub`=0 → `result`=16'h5555, `cout`=0, `overflow`=0. `busy` high 4 cycles; `done` pulses one cycle, 5 edges after the start edge.
2. **Full carry ripple:**
   - 16'hFFFF + 16'h0001, `cin`=0 → `result`=16'h0000, `cout`=1, `overflow`=0.
   - 16'h0000 + 16'h0000, `cin`=1 → `result`=16'h0001.
3. **Subtract:**
   - 16'h0005 - 16'h0007 → 16'hFFFE, `cout`=0, `overflow`=0.
   - 16'h8000 - 16'h0001 → 16'h7FFF, `cout`=1, `overflow`=1.
   - `cin`=1 during `sub` has no effect.
4. **Signed overflow:** 16'h7FFF + 16'h0001 → 16'h8000, `overflow`=1, `cout`=0. 16'hFFFF + 16'hFFFF → 16'hFFFE, `overflow`=0, `cout`=1.
5. **Ignored start and mid-op reset:**
   - Pulse `start` with new operands while `busy` → no effect on the current result.
   - Assert `rst` 2 cycles into an operation → next edge: `busy`=0, `done`=0, `result`=0, and no `done` follows.
   - Subsequent 16'h0F0F + 16'h00F1 → 16'h1000.
6. **Back-to-back:** `start` held high continuously with operands changing each operation → operations accepted every 6 cycles. Each `done` reports the operands latched at its own accept edge.

Source files
------------

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: nibble-serial adder/subtractor built around one shared
// 4-bit carry-lookahead adder (cla_4bit, defined at the bottom of this file).
//
// Operands are latched on an accepted start. One nibble is then processed
// per clock, least-significant first. The carry between passes is held in
// carry_q. When the last nibble is written, done pulses for one cycle.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset
//   start    - request, sampled only in IDLE
//   sub      - 0: A + B + cin, 1: A - B (cin ignored)
//   cin      - carry-in for add
//   op_a     - operand A, W = 4*NIBBLES bits
//   op_b     - operand B, W bits
//   busy     - operation in progress
//   done     - one-cycle pulse; result/cout/overflow are valid
//   result   - registered sum/difference, W bits
//   cout     - carry out of the MSB (for subtract, 1 = no borrow)
//   overflow - two's-complement signed overflow
module cla_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       nib_a, nib_b;
  logic [3:0]       cla_sum;
  logic             cla_cout;
  logic             msb_carry_in;

  // Operand nibble mux. A loop over the nibble positions keeps the
  // index arithmetic out of the narrow idx width.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[i*4 +: 4];
        nib_b = b_q[i*4 +: 4];
      end
    end
  end

  cla_4bit u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Sum bit 3 of the last pass is a ^ b ^ carry-in at the MSB, so the
  // carry into the MSB can be recovered without tapping the CLA.
  assign msb_carry_in = a_q[W-1] ^ b_q[W-1] ^ cla_sum[3];

  // Next-state and datapath logic. busy/done are computed here and
  // registered so no output has a combinational path from start.
  // done_d is raised while in DONE, so the done pulse appears the cycle
  // after the last nibble has settled and never overlaps busy.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            result_d[i*4 +: 4] = cla_sum;
          end
        end
        carry_d = cla_cout;
        if (idx_q == LAST_IDX) begin
          cout_d     = cla_cout;
          overflow_d = cla_cout ^ msb_carry_in;
          state_d    = DONE;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          busy_d = 1'b1;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// cla_4bit: 4-bit carry-lookahead adder.
// Ports: a, b - 4-bit addends; cin - carry-in; sum - 4-bit sum; cout - carry-out.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g, p, c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

endmodule
